// File: rtl/floppy_pkg.sv
`timescale 1ns/1ps
// floppy_pkg: shared encodings and rate tables for the floppy drive array.
package floppy_pkg;

    typedef enum logic [1:0] {
        DENS_SD     = 2'd0,
        DENS_DD     = 2'd1,
        DENS_HD     = 2'd2,
        DENS_HD_ALT = 2'd3
    } density_e;

    typedef enum logic [1:0] {
        SEC_GAP  = 2'd0,
        SEC_HDR  = 2'd1,
        SEC_DATA = 2'd2
    } sec_state_e;

    localparam int INDEX_MS  = 4;
    localparam int SPINUP_MS = 250;

    // Byte rates in bytes per second
    localparam logic [31:0] RATE_SD = 32'd15625;
    localparam logic [31:0] RATE_DD = 32'd31250;
    localparam logic [31:0] RATE_HD = 32'd62500;

    // Bytes per track (one revolution at 300 rpm)
    localparam logic [13:0] BPT_SD = 14'd3125;
    localparam logic [13:0] BPT_DD = 14'd6250;
    localparam logic [13:0] BPT_HD = 14'd12500;

    // Encoding 3 is treated as HD
    function automatic logic [31:0] byte_rate(input logic [1:0] dens);
        case (density_e'(dens))
            DENS_SD: byte_rate = RATE_SD;
            DENS_DD: byte_rate = RATE_DD;
            default: byte_rate = RATE_HD;
        endcase
    endfunction

    function automatic logic [13:0] bytes_per_track(input logic [1:0] dens);
        case (density_e'(dens))
            DENS_SD: bytes_per_track = BPT_SD;
            DENS_DD: bytes_per_track = BPT_DD;
            default: bytes_per_track = BPT_HD;
        endcase
    endfunction

endpackage

// File: rtl/floppy_drive_state.sv
`timescale 1ns/1ps
// floppy_drive_state: per-drive head position, step settle timer and spindle speed.
module floppy_drive_state
    import floppy_pkg::*;
#(
    parameter int TRACKS = 80
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_sel,
    input  logic       i_motor_on,
    input  logic       i_ms_tick,
    input  logic       i_step_in,
    input  logic       i_step_out,
    input  logic [7:0] i_step_delay_ms,
    output logic [6:0] o_track,
    output logic       o_at_speed,
    output logic       o_settled
);

    localparam logic [6:0] TRACK_MAX = 7'(TRACKS - 1);
    localparam logic [7:0] SPIN_MAX  = 8'(SPINUP_MS);

    logic [6:0] r_track;
    logic [7:0] r_spin;
    logic [7:0] r_busy;

    // Head position: each accepted step edge commits in a single cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_track <= '0;
        end else if (i_step_in && !i_step_out) begin
            if (r_track != 7'd0) r_track <= r_track - 7'd1;
        end else if (i_step_out && !i_step_in) begin
            if (r_track != TRACK_MAX) r_track <= r_track + 7'd1;
        end
    end

    // Settle timer: any step edge (even a saturated one) restarts it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else if (i_step_in || i_step_out) begin
            r_busy <= i_step_delay_ms;
        end else if (i_ms_tick && (r_busy != 8'd0)) begin
            r_busy <= r_busy - 8'd1;
        end
    end

    // Spindle speed: ramps up while selected with motor on, coasts down otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_spin <= '0;
        end else if (i_ms_tick) begin
            if (i_sel && i_motor_on) begin
                if (r_spin != SPIN_MAX) r_spin <= r_spin + 8'd1;
            end else begin
                if (r_spin != 8'd0) r_spin <= r_spin - 8'd1;
            end
        end
    end

    assign o_track    = r_track;
    assign o_at_speed = (r_spin == SPIN_MAX);
    assign o_settled  = (r_busy == 8'd0);

endmodule

// File: rtl/floppy_array.sv
`timescale 1ns/1ps
// floppy_array: emulates up to 8 floppy drives sharing one byte clock and
// sector-position tracker. sector numbering is undefined for spt=0 or
// sector_base+spt>31.
module floppy_array
    import floppy_pkg::*;
#(
    parameter int SYS_CLK = 42578000,
    parameter int DRIVES  = 4,
    parameter int TRACKS  = 80,
    parameter int HDR_LEN = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DRIVES-1:0] select,
    input  logic              motor_on,
    input  logic              step_in,
    input  logic              step_out,
    input  logic              side,
    input  logic [7:0]        step_delay_ms,
    input  logic [1:0]        density,
    input  logic [10:0]       sector_len,
    input  logic              sector_base,
    input  logic [4:0]        spt,
    input  logic [9:0]        sector_gap_len,
    output logic              dclk_en,
    output logic [6:0]        track,
    output logic              head,
    output logic [4:0]        sector,
    output logic              sector_hdr,
    output logic              sector_data,
    output logic              ready,
    output logic              track0,
    output logic              index
);

    localparam int MS_DIV     = SYS_CLK / 1000;
    localparam int PRE_W      = $clog2(MS_DIV + 1);
    localparam int INDEX_CLKS = INDEX_MS * MS_DIV;
    localparam int IDX_W      = $clog2(INDEX_CLKS + 1);

    logic [PRE_W-1:0]  r_pre;
    logic              r_ms_tick;
    logic              r_step_in_d;
    logic              r_step_out_d;
    logic [DRIVES-1:0] r_select_d;
    logic [1:0]        r_density_d;
    logic [31:0]       r_acc;
    logic              r_dclk;
    logic [13:0]       r_byte_cnt;
    logic [IDX_W-1:0]  r_idx_cnt;
    sec_state_e        r_state;
    logic [10:0]       r_state_cnt;
    logic [4:0]        r_sec_off;

    logic              r_dclk_o;
    logic [6:0]        r_track_o;
    logic              r_head_o;
    logic [4:0]        r_sector_o;
    logic              r_hdr_o;
    logic              r_data_o;
    logic              r_ready_o;
    logic              r_track0_o;
    logic              r_index_o;

    logic              w_sel_valid;
    logic              w_in_rise;
    logic              w_out_rise;
    logic              w_in_evt;
    logic              w_out_evt;
    logic              w_change;
    logic [6:0]        w_track [DRIVES];
    logic [DRIVES-1:0] w_at_speed;
    logic [DRIVES-1:0] w_settled;
    logic [6:0]        w_cur_track;
    logic              w_cur_ready;
    logic [32:0]       w_acc_sum;
    logic              w_byte_hit;
    logic [13:0]       w_bpt;
    logic              w_index_evt;
    logic [10:0]       w_gap_len;
    logic [10:0]       w_data_len;
    logic [10:0]       w_cur_len;
    sec_state_e        w_state_nxt;
    logic [10:0]       w_state_cnt_nxt;
    logic [4:0]        w_sec_off_nxt;

    // Exactly one drive selected; otherwise the array behaves as if empty
    always_comb begin
        w_sel_valid = (select != '0) && ((select & (select - DRIVES'(1))) == '0);
    end

    // Step edges; a simultaneous in/out pair is ambiguous and dropped
    assign w_in_rise  = step_in  & ~r_step_in_d;
    assign w_out_rise = step_out & ~r_step_out_d;
    assign w_in_evt   = w_in_rise  & ~w_out_rise & w_sel_valid;
    assign w_out_evt  = w_out_rise & ~w_in_rise  & w_sel_valid;

    // Reselecting or changing density restarts the rotation timing
    assign w_change = (select != r_select_d) || (density != r_density_d);

    // Millisecond prescaler and input history for edge/change detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre        <= '0;
            r_ms_tick    <= 1'b0;
            r_step_in_d  <= 1'b0;
            r_step_out_d <= 1'b0;
            r_select_d   <= '0;
            r_density_d  <= '0;
        end else begin
            r_step_in_d  <= step_in;
            r_step_out_d <= step_out;
            r_select_d   <= select;
            r_density_d  <= density;
            if (r_pre == PRE_W'(MS_DIV - 1)) begin
                r_pre     <= '0;
                r_ms_tick <= 1'b1;
            end else begin
                r_pre     <= r_pre + PRE_W'(1);
                r_ms_tick <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < DRIVES; g++) begin : g_drive
        floppy_drive_state #(
            .TRACKS(TRACKS)
        ) u_drive (
            .clk            (clk),
            .reset_n        (reset_n),
            .i_sel          (w_sel_valid & select[g]),
            .i_motor_on     (motor_on),
            .i_ms_tick      (r_ms_tick),
            .i_step_in      (w_in_evt & select[g]),
            .i_step_out     (w_out_evt & select[g]),
            .i_step_delay_ms(step_delay_ms),
            .o_track        (w_track[g]),
            .o_at_speed     (w_at_speed[g]),
            .o_settled      (w_settled[g])
        );
    end

    // Pick the selected drive's view of the head and spindle
    always_comb begin
        w_cur_track = '0;
        w_cur_ready = 1'b0;
        for (int i = 0; i < DRIVES; i++) begin
            if (w_sel_valid && select[i]) begin
                w_cur_track = w_track[i];
                w_cur_ready = w_at_speed[i] && w_settled[i];
            end
        end
    end

    assign w_acc_sum  = {1'b0, r_acc} + {1'b0, byte_rate(density)};
    assign w_byte_hit = (w_acc_sum >= 33'(SYS_CLK));

    // Fractional byte clock: one strobe per SYS_CLK/R clocks on average
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc  <= '0;
            r_dclk <= 1'b0;
        end else if (w_change) begin
            r_acc  <= '0;
            r_dclk <= 1'b0;
        end else if (w_cur_ready) begin
            r_dclk <= w_byte_hit;
            r_acc  <= w_byte_hit ? 32'(w_acc_sum - 33'(SYS_CLK)) : w_acc_sum[31:0];
        end else begin
            r_dclk <= 1'b0;
        end
    end

    assign w_bpt       = bytes_per_track(density);
    assign w_index_evt = r_dclk && (r_byte_cnt >= (w_bpt - 14'd1));

    // Angular position in bytes; the wrap marks the index hole
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_byte_cnt <= '0;
        end else if (w_change) begin
            r_byte_cnt <= '0;
        end else if (r_dclk) begin
            r_byte_cnt <= w_index_evt ? 14'd0 : r_byte_cnt + 14'd1;
        end
    end

    // Index pulse width counted in clocks so it is a full 4 ms regardless of prescaler phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx_cnt <= '0;
            r_index_o <= 1'b0;
        end else if (w_index_evt && !w_change) begin
            r_idx_cnt <= IDX_W'(INDEX_CLKS - 1);
            r_index_o <= 1'b1;
        end else if (r_idx_cnt != '0) begin
            r_idx_cnt <= r_idx_cnt - IDX_W'(1);
        end else begin
            r_index_o <= 1'b0;
        end
    end

    assign w_gap_len  = (sector_gap_len == 10'd0) ? 11'd1 : {1'b0, sector_gap_len};
    assign w_data_len = (sector_len == 11'd0) ? 11'd1 : sector_len;

    // Sector FSM next state: index/reselect realign to sector_base ahead of byte advance
    always_comb begin
        w_state_nxt     = r_state;
        w_state_cnt_nxt = r_state_cnt;
        w_sec_off_nxt   = r_sec_off;
        case (r_state)
            SEC_GAP: w_cur_len = w_gap_len;
            SEC_HDR: w_cur_len = 11'(HDR_LEN);
            default: w_cur_len = w_data_len;
        endcase
        if (w_change || w_index_evt) begin
            w_state_nxt     = SEC_GAP;
            w_state_cnt_nxt = '0;
            w_sec_off_nxt   = '0;
        end else if (r_dclk) begin
            if (({1'b0, r_state_cnt} + 12'd1) >= {1'b0, w_cur_len}) begin
                w_state_cnt_nxt = '0;
                case (r_state)
                    SEC_GAP: w_state_nxt = SEC_HDR;
                    SEC_HDR: w_state_nxt = SEC_DATA;
                    default: begin
                        w_state_nxt = SEC_GAP;
                        if (({1'b0, r_sec_off} + 6'd1) >= {1'b0, spt}) begin
                            w_sec_off_nxt = '0;
                        end else begin
                            w_sec_off_nxt = r_sec_off + 5'd1;
                        end
                    end
                endcase
            end else begin
                w_state_cnt_nxt = r_state_cnt + 11'd1;
            end
        end
    end

    // Sector FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= SEC_GAP;
            r_state_cnt <= '0;
            r_sec_off   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_state_cnt <= w_state_cnt_nxt;
            r_sec_off   <= w_sec_off_nxt;
        end
    end

    // Registered outputs, blanked when no single drive is selected
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dclk_o   <= 1'b0;
            r_track_o  <= '0;
            r_head_o   <= 1'b0;
            r_sector_o <= '0;
            r_hdr_o    <= 1'b0;
            r_data_o   <= 1'b0;
            r_ready_o  <= 1'b0;
            r_track0_o <= 1'b0;
        end else begin
            r_dclk_o   <= r_dclk && w_sel_valid;
            r_track_o  <= w_cur_track;
            r_head_o   <= side;
            r_sector_o <= {4'd0, sector_base} + r_sec_off;
            r_hdr_o    <= w_sel_valid && (r_state == SEC_HDR);
            r_data_o   <= w_sel_valid && (r_state == SEC_DATA);
            r_ready_o  <= w_cur_ready;
            r_track0_o <= w_sel_valid && (w_cur_track == 7'd0);
        end
    end

    assign dclk_en     = r_dclk_o;
    assign track       = r_track_o;
    assign head        = r_head_o;
    assign sector      = r_sector_o;
    assign sector_hdr  = r_hdr_o;
    assign sector_data = r_data_o;
    assign ready       = r_ready_o;
    assign track0      = r_track0_o;
    assign index       = r_index_o;

endmodule

// File: tb/tb_floppy_array.sv
`timescale 1ns/1ps
// tb_floppy_array: scoreboard bench for the floppy drive array, run at a scaled
// system clock (50 clocks per ms) so a spin-up and a full revolution fit the run.
module tb_floppy_array;

    localparam int SYS_CLK = 50000;
    localparam int DRIVES  = 4;
    localparam int MS      = SYS_CLK / 1000;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [DRIVES-1:0] select;
    logic              motor_on;
    logic              step_in;
    logic              step_out;
    logic              side;
    logic [7:0]        step_delay_ms;
    logic [1:0]        density;
    logic [10:0]       sector_len;
    logic              sector_base;
    logic [4:0]        spt;
    logic [9:0]        sector_gap_len;
    logic              dclk_en;
    logic [6:0]        track;
    logic              head;
    logic [4:0]        sector;
    logic              sector_hdr;
    logic              sector_data;
    logic              ready;
    logic              track0;
    logic              index;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;
    int unsigned t_release;
    int unsigned t_last_edge;
    int          exp_q[$];

    floppy_array #(
        .SYS_CLK(SYS_CLK),
        .DRIVES (DRIVES),
        .TRACKS (80),
        .HDR_LEN(6)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .select        (select),
        .motor_on      (motor_on),
        .step_in       (step_in),
        .step_out      (step_out),
        .side          (side),
        .step_delay_ms (step_delay_ms),
        .density       (density),
        .sector_len    (sector_len),
        .sector_base   (sector_base),
        .spt           (spt),
        .sector_gap_len(sector_gap_len),
        .dclk_en       (dclk_en),
        .track         (track),
        .head          (head),
        .sector        (sector),
        .sector_hdr    (sector_hdr),
        .sector_data   (sector_data),
        .ready         (ready),
        .track0        (track0),
        .index         (index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step_pulse(input bit dir_out, input int exp_track);
        exp_q.push_back(exp_track);
        @(negedge clk);
        if (dir_out) step_out = 1'b1; else step_in = 1'b1;
        t_last_edge = cyc + 1;
        repeat (2) @(negedge clk);
        step_out = 1'b0;
        step_in  = 1'b0;
        repeat (2) @(negedge clk);
        begin
            int e;
            e = exp_q.pop_front();
            checks++;
            if (track !== 7'(e)) begin
                errors++;
                $display("FAIL step_track: got %0d expected %0d", track, e);
            end
        end
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        select         = 4'b0001;
        motor_on       = 1'b1;
        step_in        = 1'b0;
        step_out       = 1'b0;
        side           = 1'b1;
        step_delay_ms  = 8'd2;
        density        = 2'd1;
        sector_len     = 11'd512;
        sector_base    = 1'b1;
        spt            = 5'd10;
        sector_gap_len = 10'd100;
        repeat (5) @(negedge clk);
        checks++;
        if ({dclk_en, track, head, sector, sector_hdr, sector_data, ready, track0, index} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {dclk_en, track, head, sector, sector_hdr, sector_data, ready, track0, index});
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 0", ready);
        end
        checks++;
        if (head !== 1'b0) begin
            errors++;
            $display("FAIL reset_head: got %b expected 0", head);
        end
        reset_n   = 1'b1;
        t_release = cyc;
    endtask

    task automatic test_spinup();
        int n;
        int last;
        int min_gap;
        int max_gap;
        while (cyc < t_release + 249 * MS) @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL spinup_early: ready=%b expected 0 at 249 ms", ready);
        end
        checks++;
        if (head !== 1'b1 || track0 !== 1'b1) begin
            errors++;
            $display("FAIL spinup_head_track0: got head=%b track0=%b expected 1 1", head, track0);
        end
        for (int i = 0; i < 20 * MS && ready !== 1'b1; i++) @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL spinup_ready: got %b expected 1 (timeout)", ready);
        end
        checks++;
        if ((cyc - t_release) < 250 * MS - 5 || (cyc - t_release) > 250 * MS + 5) begin
            errors++;
            $display("FAIL spinup_time: got %0d clks expected %0d", cyc - t_release, 250 * MS);
        end
        n = 0; last = -1; min_gap = 1000; max_gap = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (dclk_en === 1'b1) begin
                n++;
                if (last >= 0) begin
                    if (i - last < min_gap) min_gap = i - last;
                    if (i - last > max_gap) max_gap = i - last;
                end
                last = i;
            end
        end
        checks++;
        if (n < 3124 || n > 3126) begin
            errors++;
            $display("FAIL dclk_count: got %0d strobes in 5000 clks expected 3125", n);
        end
        checks++;
        if (min_gap < 1 || max_gap > 2) begin
            errors++;
            $display("FAIL dclk_spacing: got gaps %0d..%0d expected 1..2", min_gap, max_gap);
        end
    endtask

    task automatic test_steps();
        for (int i = 1; i <= 3; i++) step_pulse(1'b1, i);
        for (int i = 2; i >= -2; i--) step_pulse(1'b0, (i < 0) ? 0 : i);
        checks++;
        if (track0 !== 1'b1) begin
            errors++;
            $display("FAIL step_track0: got %b expected 1", track0);
        end
        for (int i = 0; i < 6 * MS && ready !== 1'b1; i++) @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL settle_ready: got %b expected 1 (timeout)", ready);
        end
        checks++;
        if ((cyc - t_last_edge) < 1 * MS || (cyc - t_last_edge) > 2 * MS + 4) begin
            errors++;
            $display("FAIL settle_time: got %0d clks expected %0d..%0d", cyc - t_last_edge, MS, 2 * MS + 4);
        end
    endtask

    task automatic test_index_sectors();
        bit          found;
        bit          prev_idx;
        bit          prev_hdr;
        bit          prev_data;
        bit          idx_fell;
        bit          seen2;
        int          idx_high;
        int          hdr_seen;
        int          data_seen;
        int          hdr_bytes;
        int          data_bytes;
        int unsigned t_idx;
        int unsigned period;
        int          e;
        found = 0;
        prev_idx = index;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (index === 1'b1 && prev_idx === 1'b0) begin
                found = 1;
                break;
            end
            prev_idx = index;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL index_first: no index rise within 12000 clks");
        end
        for (int s = 1; s <= 10; s++) exp_q.push_back(s);
        exp_q.push_back(1);
        t_idx = cyc; period = 0;
        prev_idx = 1; prev_hdr = sector_hdr; prev_data = sector_data;
        idx_fell = 0; seen2 = 0; idx_high = 1;
        hdr_seen = 0; data_seen = 0; hdr_bytes = 0; data_bytes = 0;
        for (int i = 0; i < 11000; i++) begin
            @(negedge clk);
            if (sector_hdr === 1'b1 && !prev_hdr) begin
                hdr_seen++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (sector !== 5'(e)) begin
                        errors++;
                        $display("FAIL sector_seq: got %0d expected %0d", sector, e);
                    end
                end
            end
            if (sector_data === 1'b1 && !prev_data) data_seen++;
            if (hdr_seen == 1 && sector_hdr === 1'b1 && dclk_en === 1'b1) hdr_bytes++;
            if (data_seen == 1 && sector_data === 1'b1 && dclk_en === 1'b1) data_bytes++;
            if (!idx_fell) begin
                if (index === 1'b1) idx_high++; else idx_fell = 1;
            end
            if (index === 1'b1 && !prev_idx && !seen2) begin
                period = cyc - t_idx;
                seen2  = 1;
            end
            prev_idx  = index;
            prev_hdr  = sector_hdr;
            prev_data = sector_data;
            if (seen2 && exp_q.size() == 0) break;
        end
        checks++;
        if (exp_q.size() != 0 || !seen2) begin
            errors++;
            $display("FAIL sector_timeout: %0d sectors unseen, second index=%0d", exp_q.size(), seen2);
        end
        exp_q.delete();
        checks++;
        if (idx_high < 4 * MS - 1 || idx_high > 4 * MS + 1) begin
            errors++;
            $display("FAIL index_width: got %0d clks expected %0d", idx_high, 4 * MS);
        end
        checks++;
        if (period < 200 * MS - 1 || period > 200 * MS + 1) begin
            errors++;
            $display("FAIL index_period: got %0d clks expected %0d", period, 200 * MS);
        end
        checks++;
        if (hdr_bytes != 6) begin
            errors++;
            $display("FAIL hdr_len: got %0d bytes expected 6", hdr_bytes);
        end
        checks++;
        if (data_bytes != 512) begin
            errors++;
            $display("FAIL data_len: got %0d bytes expected 512", data_bytes);
        end
    endtask

    task automatic test_select();
        int unsigned t0;
        for (int i = 1; i <= 5; i++) step_pulse(1'b1, i);
        @(negedge clk);
        select = 4'b0100;
        repeat (3) @(negedge clk);
        checks++;
        if (track !== 7'd0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL select_drive2: got track=%0d ready=%b expected 0 0", track, ready);
        end
        repeat (20 * MS) @(negedge clk);
        select = 4'b0001;
        t0 = cyc;
        exp_q.push_back(5);
        repeat (3) @(negedge clk);
        begin
            int e;
            e = exp_q.pop_front();
            checks++;
            if (track !== 7'(e) || ready !== 1'b0) begin
                errors++;
                $display("FAIL reselect_track: got track=%0d ready=%b expected %0d 0", track, ready, e);
            end
        end
        for (int i = 0; i < 60 * MS && ready !== 1'b1; i++) @(negedge clk);
        checks++;
        if (ready !== 1'b1 || (cyc - t0) > 125 * MS) begin
            errors++;
            $display("FAIL reselect_ready: got ready=%b after %0d clks expected 1 well before %0d", ready, cyc - t0, 250 * MS);
        end
    endtask

    task automatic test_illegal();
        bit any_dclk;
        bit any_ready;
        bit any_data;
        bit any_trk;
        @(negedge clk);
        select = 4'b0011;
        any_dclk = 0; any_ready = 0; any_data = 0; any_trk = 0;
        @(negedge clk);
        for (int i = 0; i < 10 * MS; i++) begin
            if (i == 100) step_out = 1'b1;
            if (i == 104) step_out = 1'b0;
            @(negedge clk);
            if (dclk_en !== 1'b0) any_dclk = 1;
            if (ready !== 1'b0) any_ready = 1;
            if (sector_data !== 1'b0) any_data = 1;
            if (track !== 7'd0 || track0 !== 1'b0) any_trk = 1;
        end
        checks++;
        if (any_dclk || any_ready || any_data) begin
            errors++;
            $display("FAIL illegal_select: got dclk=%b ready=%b data=%b expected all 0", any_dclk, any_ready, any_data);
        end
        checks++;
        if (any_trk) begin
            errors++;
            $display("FAIL illegal_track: track/track0 nonzero with no drive selected, expected 0");
        end
        select = 4'b0001;
        exp_q.push_back(5);
        repeat (3) @(negedge clk);
        begin
            int e;
            e = exp_q.pop_front();
            checks++;
            if (track !== 7'(e)) begin
                errors++;
                $display("FAIL illegal_step_ignored: got track %0d expected %0d", track, e);
            end
        end
        for (int i = 0; i < 40 * MS && ready !== 1'b1; i++) @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal_recover: got ready=%b expected 1 (timeout)", ready);
        end
        exp_q.push_back(5);
        @(negedge clk);
        step_in  = 1'b1;
        step_out = 1'b1;
        repeat (3) @(negedge clk);
        step_in  = 1'b0;
        step_out = 1'b0;
        repeat (3) @(negedge clk);
        begin
            int e;
            e = exp_q.pop_front();
            checks++;
            if (track !== 7'(e) || ready !== 1'b1) begin
                errors++;
                $display("FAIL step_conflict: got track=%0d ready=%b expected %0d 1", track, ready, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 0;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (sector_data === 1'b1) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_data: sector_data never seen");
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({dclk_en, track, head, sector, sector_hdr, sector_data, ready, track0, index} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0",
                     {dclk_en, track, head, sector, sector_hdr, sector_data, ready, track0, index});
        end
        repeat (3) @(negedge clk);
        reset_n   = 1'b1;
        t_release = cyc;
        repeat (50 * MS) @(negedge clk);
        checks++;
        if (ready !== 1'b0 || track !== 7'd0) begin
            errors++;
            $display("FAIL post_reset: got ready=%b track=%0d expected 0 0", ready, track);
        end
        for (int i = 0; i < 220 * MS && ready !== 1'b1; i++) @(negedge clk);
        checks++;
        if (ready !== 1'b1 || (cyc - t_release) < 250 * MS - 5 || (cyc - t_release) > 250 * MS + 5) begin
            errors++;
            $display("FAIL respin_time: got ready=%b after %0d clks expected 1 after %0d", ready, cyc - t_release, 250 * MS);
        end
    endtask

    initial begin
        test_reset();
        test_spinup();
        test_steps();
        test_index_sectors();
        test_select();
        test_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/floppy_array.md
FLOPPY_ARRAY -- requirements
Module: floppy_array

Interface
REQ-001 SHALL have parameter SYS_CLK, default 42578000, system clock frequency in Hz.
REQ-002 SHALL have parameter DRIVES, default 4, number of emulated drives (1..8).
REQ-003 SHALL have parameter TRACKS, default 80, track count per drive (2..128).
REQ-004 SHALL have parameter HDR_LEN, default 6, sector header length in bytes.
REQ-005 SHALL have ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- select  in  DRIVES  one-hot drive select.
- motor_on  in  1  motor request for the selected drive.
- step_in  in  1  step toward track 0, rising edge.
- step_out  in  1  step away from track 0, rising edge.
- side  in  1  head select.
- step_delay_ms  in  8  head settle time in ms.
- density  in  2  0 SD, 1 DD, 2 HD; 3 treated as HD.
- sector_len  in  11  data bytes per sector.
- sector_base  in  1  number of the first sector.
- spt  in  5  sectors per track.
- sector_gap_len  in  10  gap bytes per sector.
- dclk_en  out  1  one-cycle byte strobe.
- track  out  7  track of the selected drive.
- head  out  1  registered side.
- sector  out  5  sector under the head.
- sector_hdr  out  1  header bytes under the head.
- sector_data  out  1  data bytes under the head.
- ready  out  1  selected drive at speed and settled.
- track0  out  1  selected drive on track 0.
- index  out  1  index hole, active high.

Function
REQ-006 A ms prescaler SHALL pulse ms_tick once every SYS_CLK/1000 clocks.
REQ-007 Each drive SHALL keep a track register (0..TRACKS-1), a step_busy ms counter and a spin counter (0..250).
REQ-008 Spin counter SHALL increment per ms_tick while that drive is selected with motor_on=1, decrement while it is not, and saturate at 0 and 250. Drives keep spinning down while deselected.
REQ-009 Step edges SHALL apply only to the selected drive:
- step_in edge: decrement track, saturating at 0.
- step_out edge: increment track, saturating at TRACKS-1.
- Either edge reloads step_busy with step_delay_ms, including while busy and including a saturated step.
REQ-010 Rising edges of step_in and step_out in the same cycle SHALL both be ignored.
REQ-011 If select is not one-hot, there SHALL be no selected drive: ready=0, dclk_en=0, track=0, track0=0, sector_hdr=0, sector_data=0, and step edges ignored.
REQ-012 ready SHALL be 1 only when the selected drive's spin counter = 250 and its step_busy = 0.
REQ-013 Byte clock: while ready, a 32-bit accumulator SHALL add byte rate R each clk (R = 15625/31250/62500 for SD/DD/HD). When the sum reaches SYS_CLK, it subtracts SYS_CLK and pulses dclk_en for one cycle. While not ready, the accumulator holds.
REQ-014 A byte counter SHALL count dclk_en pulses modulo BPT (3125/6250/12500 for SD/DD/HD). Each wrap to 0 is an index event.
REQ-015 index SHALL assert on the clock after an index event and stay high for 4 ms_ticks.
REQ-016 Sector FSM states: GAP, HDR, DATA, advanced on dclk_en.
- Byte lengths: GAP = max(sector_gap_len,1), HDR = HDR_LEN, DATA = max(sector_len,1).
- Transitions: GAP->HDR->DATA->GAP.
- DATA->GAP increments sector, wrapping from sector_base+spt-1 to sector_base.
REQ-017 An index event SHALL force state GAP, reload the gap count and set sector = sector_base, with priority over the normal advance.
REQ-018 A change in the select vector or density SHALL clear the byte counter, the accumulator and the FSM (GAP, sector = sector_base) on the next clock.
REQ-019 head SHALL register side every clock. side SHALL NOT affect timing.
REQ-020 Parameter values spt=0 and spt+sector_base>31 SHALL be documented as undefined.

Reset
REQ-021 While reset_n=0, all of the following SHALL be cleared asynchronously:
- All tracks, spin counters, step_busy counters, accumulator, byte counter, index timer and prescaler to 0.
- FSM to GAP, with sector = sector_base.
- All outputs to 0.
REQ-022 Reset asserted mid-rotation or mid-step SHALL abort the operation. No partial step SHALL be committed.

Structure
REQ-023 The shared package floppy_pkg SHALL hold: the density encoding, the sector-state enum, the R and BPT constant tables, INDEX_MS=4, SPINUP_MS=250.
REQ-024 Per-drive state SHALL live in sub-module floppy_drive_state (track, spin, step_busy, edge handling), instantiated DRIVES times by generate.

Verification (SYS_CLK=1000000, DRIVES=4)
REQ-025 Select drive 0 with motor_on, DD: ready rises after 250 ms_ticks (250000 clks); dclk_en then pulses every 32 clks.
REQ-026 Three step_out edges, then step_in×5: track 3 then 0, track0=1; ready low for step_delay_ms after the last edge.
REQ-027 Index and sectors, DD, spt=10, sector_base=1, gap=100, len=512:
- index period is 200000 clks and high for 4000 clks.
- sector sequence is 1..10, then back to 1 at index.
- sector_hdr lasts 6 bytes.
REQ-028 Stepping and selection:
- Step drive 0 to track 5.
- Select drive 2: track=0, ready=0.
- Reselect drive 0 within 250 ms: track=5, ready without the full spin-up.
REQ-029 Illegal select and edge conflict:
- select=4'b0011: dclk_en, ready and sector_data stay 0.
- Simultaneous step_in/step_out edges: track unchanged.
REQ-030 reset_n low mid-DATA: all outputs 0 immediately; after release, spin-up restarts from 0.
